// File: rtl/mem_if_pkg.sv
// Shared types and constants for the handshaked data-memory responder.
// Request capture struct, FSM encoding and address-check constants.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

endpackage

// File: rtl/mem_word_array.sv
// DEPTH_WORDS x 32 storage with synchronous byte-enabled write and no reset.
// The read port is combinational; the responder samples it on the commit edge.
module mem_word_array #(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = 6
) (
  input  logic          gclk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge gclk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side end of the core's load/store channel: one outstanding request,
// response after LATENCY edges, held until the initiator takes it.
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWE,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  input  logic [3:0]  ReqByteEn,
  output logic        RespValid,
  input  logic        RespReady,
  output logic [31:0] RespRData,
  output logic        RespErr
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic        commit;
  req_t        req;
  logic [31:0] off;
  logic        err;
  logic [31:0] arr_rdata;
  logic [31:0] rdata_q;
  logic        err_q;

  // Offset wraps for addresses below BASE_ADDR, so one unsigned compare covers both ends.
  assign off = req.addr - BASE_ADDR;
  assign err = ((req.addr[1:0] & WORD_ALIGN_MASK) != 2'b00) || (off >= SPAN);

  // Counter starts at LATENCY-1 so the commit edge lands exactly LATENCY edges
  // after acceptance, including LATENCY == 1.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        if (ReqValid) begin
          state_d = WAIT;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      RESP: begin
        if (RespReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      req     <= '{we: 1'b0, addr: '0, wdata: '0, be: BE_NONE};
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE && ReqValid)
        req <= '{we: ReqWE, addr: ReqAddr, wdata: ReqWData, be: ReqByteEn};
      if (commit) begin
        err_q   <= err;
        rdata_q <= (!err && !req.we) ? arr_rdata : '0;
      end else if (state == RESP && RespReady) begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

  mem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .gclk  (Clk),
    .we    (commit && !err && req.we),
    .be    (req.be),
    .addr  (off[AW+1:2]),
    .wdata (req.wdata),
    .rdata (arr_rdata)
  );

  assign ReqReady  = (state == IDLE);
  assign RespValid = (state == RESP);
  assign RespRData = rdata_q;
  assign RespErr   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: four responders (latency 2/1/15/4) driven by directed
// steps and random traffic, checked against a word-array reference model.
module tb_mem_responder;

  localparam int          N = 4;
  localparam int          LATS  [N] = '{2, 1, 15, 4};
  localparam logic [31:0] BASES [N] = '{32'h0, 32'h0, 32'h0000_1000, 32'h0};

  logic        clk = 1'b0;
  logic        rst_n      [N];
  logic        req_valid  [N];
  logic        req_ready  [N];
  logic        req_we     [N];
  logic [31:0] req_addr   [N];
  logic [31:0] req_wdata  [N];
  logic [3:0]  req_be     [N];
  logic        resp_valid [N];
  logic        resp_ready [N];
  logic [31:0] resp_rdata [N];
  logic        resp_err   [N];

  logic [31:0] mdl [N][64];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_responder #(
      .DEPTH_WORDS (64),
      .LATENCY     (LATS[g]),
      .BASE_ADDR   (BASES[g])
    ) dut (
      .Clk       (clk),
      .Reset     (rst_n[g]),
      .ReqValid  (req_valid[g]),
      .ReqReady  (req_ready[g]),
      .ReqWE     (req_we[g]),
      .ReqAddr   (req_addr[g]),
      .ReqWData  (req_wdata[g]),
      .ReqByteEn (req_be[g]),
      .RespValid (resp_valid[g]),
      .RespReady (resp_ready[g]),
      .RespRData (resp_rdata[g]),
      .RespErr   (resp_err[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int k, input string tag);
    chk({tag, ".ready"}, 32'(req_ready[k]), 32'd1);
    chk({tag, ".valid"}, 32'(resp_valid[k]), 32'd0);
    chk({tag, ".rdata"}, resp_rdata[k], 32'd0);
    chk({tag, ".err"},   32'(resp_err[k]), 32'd0);
  endtask

  // One full transaction on instance k; expectations come from the model.
  task automatic do_req(input int k, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        input int hold, input logic rr_wait, input string tag);
    logic [31:0] off, exp_d, got_d;
    logic        exp_e;
    int          n;
    off   = addr - BASES[k];
    exp_e = (addr[1:0] != 2'b00) || (off >= 32'd256);
    exp_d = 32'd0;
    if (!exp_e) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) mdl[k][off[7:2]][8*i +: 8] = wd[8*i +: 8];
      end else begin
        exp_d = mdl[k][off[7:2]];
      end
    end
    @(negedge clk);
    n = 0;
    while (!req_ready[k] && n < 50) begin @(negedge clk); n++; end
    chk({tag, ".rdy_before"}, 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = addr;
    req_wdata[k] = wd;   req_be[k] = be; resp_ready[k] = rr_wait;
    @(posedge clk);
    @(negedge clk);
    req_valid[k] = 1'b0; req_we[k] = ~we; req_addr[k] = $urandom;
    req_wdata[k] = $urandom; req_be[k] = 4'($urandom);
    chk({tag, ".rdy_busy"}, 32'(req_ready[k]), 32'd0);
    n = 0;
    while (!resp_valid[k] && n < 40) begin @(negedge clk); n++; end
    chk({tag, ".lat"},   32'(n), 32'(LATS[k]));
    chk({tag, ".err"},   32'(resp_err[k]), 32'(exp_e));
    chk({tag, ".rdata"}, resp_rdata[k], exp_d);
    got_d = resp_rdata[k];
    for (int h = 0; h < hold; h++) begin
      resp_ready[k] = 1'b0;
      req_valid[k] = 1'b1; req_we[k] = 1'b1; req_addr[k] = BASES[k];
      req_wdata[k] = 32'hBAD0_0000 | 32'(h); req_be[k] = 4'hF;
      @(negedge clk);
      chk({tag, ".hold_valid"}, 32'(resp_valid[k]), 32'd1);
      chk({tag, ".hold_rdata"}, resp_rdata[k], got_d);
      chk({tag, ".hold_ready"}, 32'(req_ready[k]), 32'd0);
    end
    req_valid[k] = 1'b0;
    resp_ready[k] = 1'b1;
    @(negedge clk);
    resp_ready[k] = 1'b0;
    chk_idle(k, {tag, ".pop"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] off;
    int r, n;
    for (int k = 0; k < N; k++) begin
      rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
      req_wdata[k] = '0; req_be[k] = '0; resp_ready[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk_idle(0, "reset_held");
    for (int k = 0; k < N; k++) rst_n[k] = 1'b1;
    @(negedge clk);
    chk_idle(0, "reset_rel");

    // Give every word a known value so later reads are fully predictable.
    for (int k = 0; k < N; k++)
      for (int w = 0; w < 64; w++)
        do_req(k, 1'b1, BASES[k] + 32'(w * 4), $urandom, 4'hF, 0, 1'b1, "fill");

    // Read-back and byte lanes, latency 2.
    do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, "wr10");
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, "rd10");
    do_req(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 0, 1'b0, "wr20");
    do_req(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 0, 1'b0, "wr20be");
    do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, "rd20");
    chk("lanes_const", mdl[0][8], 32'h11BB_33DD);
    do_req(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 0, 1'b0, "wr_be0");
    do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, "rd_be0");

    // Error cases.
    do_req(0, 1'b0, 32'h102, 32'h0, 4'h0, 0, 1'b0, "rd_mis");
    do_req(0, 1'b1, 32'h100, 32'h5555_5555, 4'hF, 0, 1'b0, "wr_oor");
    do_req(0, 1'b1, 32'hFC, 32'h0BAD_0FFC, 4'hF, 0, 1'b0, "wr_last");
    do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, "rd0");

    // Backpressure with a competing request held on the request channel.
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b0, "bp");
    do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, "bp_rd0");

    // Reset two cycles into WAIT drops the pending write (latency 4).
    do_req(3, 1'b1, 32'h8, 32'h1234_5678, 4'hF, 0, 1'b0, "pre8");
    @(negedge clk);
    req_valid[3] = 1'b1; req_we[3] = 1'b1; req_addr[3] = 32'h8;
    req_wdata[3] = 32'hCAFE_F00D; req_be[3] = 4'hF;
    @(posedge clk); @(negedge clk);
    req_valid[3] = 1'b0;
    repeat (2) @(negedge clk);
    chk("midwait.valid", 32'(resp_valid[3]), 32'd0);
    rst_n[3] = 1'b0;
    #1;
    chk_idle(3, "rst_wait");
    repeat (2) @(negedge clk);
    rst_n[3] = 1'b1;
    do_req(3, 1'b0, 32'h8, 32'h0, 4'h0, 0, 1'b0, "rd8_after_rst");

    // Reset while in RESP keeps the already-committed write.
    @(negedge clk);
    req_valid[3] = 1'b1; req_we[3] = 1'b1; req_addr[3] = 32'hC;
    req_wdata[3] = 32'h0BAD_F00D; req_be[3] = 4'hF;
    mdl[3][3] = 32'h0BAD_F00D;
    @(posedge clk); @(negedge clk);
    req_valid[3] = 1'b0;
    n = 0;
    while (!resp_valid[3] && n < 40) begin @(negedge clk); n++; end
    chk("inresp.valid", 32'(resp_valid[3]), 32'd1);
    rst_n[3] = 1'b0;
    #1;
    chk_idle(3, "rst_resp");
    @(negedge clk);
    rst_n[3] = 1'b1;
    do_req(3, 1'b0, 32'hC, 32'h0, 4'h0, 0, 1'b0, "rdC_after_rst");

    // Random traffic: latency 1 and 15 with RespReady tied high, latency 2 with stalls.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 100; i++) begin
        r   = $urandom_range(0, 9);
        off = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        if (r == 0) off = off | 32'($urandom_range(1, 3));
        else if (r == 1) off = off + 32'h100 * 32'($urandom_range(1, 4));
        else if (r == 2) off = 32'hFFFF_FFFC;
        if (k == 0)
          do_req(k, 1'($urandom), BASES[k] + off, $urandom, 4'($urandom),
                 $urandom_range(0, 2), 1'($urandom), "rnd");
        else
          do_req(k, 1'($urandom), BASES[k] + off, $urandom, 4'($urandom), 0, 1'b1, "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
